// File: rtl/execute_stage_if.sv
// Decode-to-execute handshake plus the registered execute outputs that feed
// the memory-access stage.
interface execute_stage_if #(
    parameter int WIDTH = 16
);
    logic             valid_id;
    logic [3:0]       control_id;
    logic [WIDTH-1:0] operand_a_id;
    logic [WIDTH-1:0] operand_b_id;
    logic [WIDTH-1:0] reg_data_id;
    logic [4:0]       dest_reg_index_id;
    logic             dest_reg_write_en_id;
    logic             flush_ex;
    logic             stall_ex;
    logic [3:0]       control_ex;
    logic [WIDTH-1:0] result_ex;
    logic [WIDTH-1:0] reg_data_ex;
    logic [4:0]       dest_reg_index_ex;
    logic             dest_reg_write_en_ex;
    logic [3:0]       flags_ex;

    // Upstream/downstream side: decode drives operands, memory stage reads results
    modport master (
        output valid_id, control_id, operand_a_id, operand_b_id, reg_data_id,
               dest_reg_index_id, dest_reg_write_en_id, flush_ex,
        input  stall_ex, control_ex, result_ex, reg_data_ex,
               dest_reg_index_ex, dest_reg_write_en_ex, flags_ex
    );

    modport slave (
        input  valid_id, control_id, operand_a_id, operand_b_id, reg_data_id,
               dest_reg_index_id, dest_reg_write_en_id, flush_ex,
        output stall_ex, control_ex, result_ex, reg_data_ex,
               dest_reg_index_ex, dest_reg_write_en_ex, flags_ex
    );
endinterface

// File: rtl/execute_stage.sv
// Pipeline execute stage: single-cycle ALU and address generation, plus a
// 16-step iterative shift-add multiplier that stalls decode while it runs.
module execute_stage #(
    parameter int         WIDTH     = 16,
    parameter int         MUL_STEPS = 16,
    parameter logic [3:0] NOP_OP    = 4'b1111
) (
    input logic           clk,
    input logic           reset,
    execute_stage_if.slave bus
);
    localparam int CW = $clog2(MUL_STEPS);
    localparam int SW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(MUL_STEPS - 1);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOT   = 4'b0101;
    localparam logic [3:0] OP_SHL   = 4'b0110;
    localparam logic [3:0] OP_SHR   = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_LOAD  = 4'b1101;
    localparam logic [3:0] OP_STORE = 4'b1110;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count, count_next;
    logic [WIDTH-1:0] mcand, mcand_next;
    logic [WIDTH-1:0] mplier, mplier_next;
    logic [WIDTH-1:0] acc, acc_next;
    logic [4:0]       mul_idx, mul_idx_next;
    logic             mul_we, mul_we_next;

    logic [3:0]       ctrl_q, ctrl_n;
    logic [WIDTH-1:0] result_q, result_n;
    logic [WIDTH-1:0] reg_data_q, reg_data_n;
    logic [4:0]       idx_q, idx_n;
    logic             we_q, we_n;
    logic [3:0]       flags_q, flags_n;
    logic             stall;

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_result, acc_step, a, b;
    logic [3:0]       alu_flags;
    logic             alu_valid;

    assign a        = bus.operand_a_id;
    assign b        = bus.operand_b_id;
    assign sum      = {1'b0, a} + {1'b0, b};
    assign diff     = {1'b0, a} - {1'b0, b};
    assign acc_step = acc + (mplier[0] ? mcand : '0);

    // Single-cycle datapath; flags default to held and only ADD/SUB refresh them
    always_comb begin
        alu_result = '0;
        alu_flags  = flags_q;
        alu_valid  = 1'b1;
        case (bus.control_id)
            OP_ADD: begin
                alu_result = sum[WIDTH-1:0];
                alu_flags  = {sum[WIDTH-1:0] == '0, sum[WIDTH-1], sum[WIDTH],
                              (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1])};
            end
            OP_SUB: begin
                alu_result = diff[WIDTH-1:0];
                alu_flags  = {diff[WIDTH-1:0] == '0, diff[WIDTH-1], diff[WIDTH],
                              (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1])};
            end
            OP_AND:   alu_result = a & b;
            OP_OR:    alu_result = a | b;
            OP_XOR:   alu_result = a ^ b;
            OP_NOT:   alu_result = ~a;
            OP_SHL:   alu_result = a << b[SW-1:0];
            OP_SHR:   alu_result = a >> b[SW-1:0];
            OP_LOAD,
            OP_STORE: alu_result = sum[WIDTH-1:0];
            default:  alu_valid  = 1'b0;
        endcase
    end

    // Next-state and output-register logic; flush outranks MUL start and completion
    always_comb begin
        state_next   = state;
        count_next   = count;
        mcand_next   = mcand;
        mplier_next  = mplier;
        acc_next     = acc;
        mul_idx_next = mul_idx;
        mul_we_next  = mul_we;
        ctrl_n       = NOP_OP;
        result_n     = '0;
        reg_data_n   = '0;
        idx_n        = '0;
        we_n         = 1'b0;
        flags_n      = flags_q;
        stall        = 1'b0;

        if (bus.flush_ex) begin
            state_next = IDLE;
            count_next = '0;
        end else if (state == IDLE) begin
            if (bus.valid_id && bus.control_id == OP_MUL) begin
                state_next   = BUSY;
                count_next   = '0;
                acc_next     = '0;
                mcand_next   = a;
                mplier_next  = b;
                mul_idx_next = bus.dest_reg_index_id;
                mul_we_next  = bus.dest_reg_write_en_id;
                stall        = 1'b1;
            end else if (bus.valid_id && alu_valid) begin
                ctrl_n     = bus.control_id;
                result_n   = alu_result;
                reg_data_n = (bus.control_id == OP_STORE) ? bus.reg_data_id : '0;
                idx_n      = bus.dest_reg_index_id;
                we_n       = bus.dest_reg_write_en_id;
                flags_n    = alu_flags;
            end
        end else begin
            acc_next    = acc_step;
            mcand_next  = mcand << 1;
            mplier_next = mplier >> 1;
            count_next  = count + CW'(1);
            if (count == LAST_STEP) begin
                state_next = IDLE;
                count_next = '0;
                ctrl_n     = OP_MUL;
                result_n   = acc_step;
                idx_n      = mul_idx;
                we_n       = mul_we;
                flags_n    = {acc_step == '0, acc_step[WIDTH-1], 1'b0, 1'b0};
            end else begin
                stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            mul_idx    <= '0;
            mul_we     <= 1'b0;
            ctrl_q     <= NOP_OP;
            result_q   <= '0;
            reg_data_q <= '0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            flags_q    <= '0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            mcand      <= mcand_next;
            mplier     <= mplier_next;
            acc        <= acc_next;
            mul_idx    <= mul_idx_next;
            mul_we     <= mul_we_next;
            ctrl_q     <= ctrl_n;
            result_q   <= result_n;
            reg_data_q <= reg_data_n;
            idx_q      <= idx_n;
            we_q       <= we_n;
            flags_q    <= flags_n;
        end
    end

    assign bus.stall_ex             = stall && !reset;
    assign bus.control_ex           = ctrl_q;
    assign bus.result_ex            = result_q;
    assign bus.reg_data_ex          = reg_data_q;
    assign bus.dest_reg_index_ex    = idx_q;
    assign bus.dest_reg_write_en_ex = we_q;
    assign bus.flags_ex             = flags_q;
endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push expected results,
// a negedge monitor pops and compares whenever a non-bubble result appears.
module tb_execute_stage;
    localparam logic [3:0] NOP = 4'b1111;

    typedef struct {
        logic [3:0]  ctrl;
        logic [15:0] result;
        logic [15:0] reg_data;
        logic [4:0]  idx;
        logic        we;
        logic [3:0]  flags;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t mon_e;

    execute_stage_if bus();

    execute_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] ctrl, input logic [15:0] a,
                                 input logic [15:0] b, input logic [15:0] rd,
                                 input logic [4:0] idx, input logic we);
        bus.valid_id             = 1'b1;
        bus.control_id           = ctrl;
        bus.operand_a_id         = a;
        bus.operand_b_id         = b;
        bus.reg_data_id          = rd;
        bus.dest_reg_index_id    = idx;
        bus.dest_reg_write_en_id = we;
        bus.flush_ex             = 1'b0;
    endtask

    task automatic setIdle();
        applyStimulus(NOP, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);
        bus.valid_id = 1'b0;
    endtask

    task automatic pushExpect(input logic [3:0] ctrl, input logic [15:0] result,
                              input logic [15:0] rd, input logic [4:0] idx,
                              input logic we, input logic [3:0] flags);
        exp_t e;
        e.ctrl = ctrl; e.result = result; e.reg_data = rd;
        e.idx = idx; e.we = we; e.flags = flags;
        sb.push_back(e);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Issue a single-cycle op together with its hand-computed expectation
    task automatic issueOp(input logic [3:0] ctrl, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] rd,
                           input logic [4:0] idx, input logic we,
                           input logic [15:0] exp_result, input logic [15:0] exp_rd,
                           input logic [3:0] exp_flags);
        applyStimulus(ctrl, a, b, rd, idx, we);
        pushExpect(ctrl, exp_result, exp_rd, idx, we, exp_flags);
        stepCycle();
    endtask

    always @(negedge clk) begin
        if (!reset && bus.control_ex != NOP) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output actual control=%b result=%h required no output",
                         bus.control_ex, bus.result_ex);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("control_ex", 16'(bus.control_ex), 16'(mon_e.ctrl));
                checkOutput("result_ex", bus.result_ex, mon_e.result);
                checkOutput("reg_data_ex", bus.reg_data_ex, mon_e.reg_data);
                checkOutput("dest_reg_index_ex", 16'(bus.dest_reg_index_ex), 16'(mon_e.idx));
                checkOutput("dest_reg_write_en_ex", 16'(bus.dest_reg_write_en_ex), 16'(mon_e.we));
                checkOutput("flags_ex", 16'(bus.flags_ex), 16'(mon_e.flags));
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        applyStimulus(4'b1000, 16'h1111, 16'h2222, 16'h3333, 5'd31, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_control", 16'(bus.control_ex), 16'(NOP));
        checkOutput("reset_we", 16'(bus.dest_reg_write_en_ex), 16'h0);
        checkOutput("reset_result", bus.result_ex, 16'h0);
        checkOutput("reset_flags", 16'(bus.flags_ex), 16'h0);
        checkOutput("reset_stall", 16'(bus.stall_ex), 16'h0);
        setIdle();
        reset = 1'b0;
        stepCycle();

        issueOp(4'b0000, 16'h7FFF, 16'h0001, 16'h0000, 5'd1, 1'b1, 16'h8000, 16'h0, 4'b0101);
        issueOp(4'b0001, 16'h0000, 16'h0001, 16'h0000, 5'd2, 1'b1, 16'hFFFF, 16'h0, 4'b0110);
        issueOp(4'b1110, 16'h0010, 16'h0005, 16'hBEEF, 5'd3, 1'b0, 16'h0015, 16'hBEEF, 4'b0110);
        issueOp(4'b0010, 16'hF0F0, 16'h3C3C, 16'h1111, 5'd4, 1'b1, 16'h3030, 16'h0, 4'b0110);
        issueOp(4'b0011, 16'hF0F0, 16'h0F00, 16'h0000, 5'd5, 1'b1, 16'hFFF0, 16'h0, 4'b0110);
        issueOp(4'b0100, 16'hFFFF, 16'h00FF, 16'h0000, 5'd6, 1'b1, 16'hFF00, 16'h0, 4'b0110);
        issueOp(4'b0101, 16'h00FF, 16'h1234, 16'h0000, 5'd7, 1'b1, 16'hFF00, 16'h0, 4'b0110);
        issueOp(4'b0110, 16'h0001, 16'h001F, 16'h0000, 5'd8, 1'b1, 16'h8000, 16'h0, 4'b0110);
        issueOp(4'b0111, 16'h8000, 16'h0010, 16'h0000, 5'd9, 1'b1, 16'h8000, 16'h0, 4'b0110);
        issueOp(4'b0111, 16'hF000, 16'h0004, 16'h0000, 5'd10, 1'b1, 16'h0F00, 16'h0, 4'b0110);
        issueOp(4'b1101, 16'h00F0, 16'h0010, 16'h1234, 5'd11, 1'b1, 16'h0100, 16'h0, 4'b0110);
        issueOp(4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 5'd12, 1'b1, 16'h0000, 16'h0, 4'b1010);

        applyStimulus(4'b1010, 16'h1234, 16'h5678, 16'h9ABC, 5'd13, 1'b1);
        stepCycle();
        checkOutput("illegal_op_bubble", 16'(bus.control_ex), 16'(NOP));
        checkOutput("illegal_op_result", bus.result_ex, 16'h0);
        checkOutput("illegal_op_flags_held", 16'(bus.flags_ex), 16'hA);
        bus.valid_id = 1'b0;
        bus.control_id = 4'b0000;
        stepCycle();
        checkOutput("invalid_bubble_we", 16'(bus.dest_reg_write_en_ex), 16'h0);

        // Full multiply followed by an ADD accepted as stall drops
        applyStimulus(4'b1000, 16'h0123, 16'h0045, 16'h7777, 5'd9, 1'b1);
        pushExpect(4'b1000, 16'h4E6F, 16'h0, 5'd9, 1'b1, 4'b0000);
        #1;
        checkOutput("mul_stall_cycle0", 16'(bus.stall_ex), 16'h1);
        for (int k = 1; k <= 16; k++) begin
            stepCycle();
            checkOutput($sformatf("mul_stall_cycle%0d", k), 16'(bus.stall_ex),
                        (k < 16) ? 16'h1 : 16'h0);
            checkOutput($sformatf("mul_bubble_cycle%0d", k), 16'(bus.control_ex), 16'(NOP));
        end
        stepCycle();
        issueOp(4'b0000, 16'h0001, 16'h0002, 16'h0000, 5'd4, 1'b1, 16'h0003, 16'h0, 4'b0000);

        // Multiply aborted by a flush in BUSY cycle 5
        applyStimulus(4'b1000, 16'h00FF, 16'h0101, 16'h0000, 5'd5, 1'b1);
        #1;
        checkOutput("flushmul_stall_start", 16'(bus.stall_ex), 16'h1);
        repeat (5) stepCycle();
        bus.flush_ex = 1'b1;
        #1;
        checkOutput("flush_forces_stall_low", 16'(bus.stall_ex), 16'h0);
        stepCycle();
        checkOutput("flush_bubble", 16'(bus.control_ex), 16'(NOP));
        applyStimulus(4'b0000, 16'h0002, 16'h0003, 16'h0000, 5'd6, 1'b1);
        #1;
        checkOutput("after_flush_stall", 16'(bus.stall_ex), 16'h0);
        pushExpect(4'b0000, 16'h0005, 16'h0, 5'd6, 1'b1, 4'b0000);
        stepCycle();

        // Multiply aborted by async reset in BUSY cycle 8, then a clean multiply
        issueOp(4'b0001, 16'h0001, 16'h0002, 16'h0000, 5'd10, 1'b1, 16'hFFFF, 16'h0, 4'b0110);
        applyStimulus(4'b1000, 16'h0003, 16'h0004, 16'h0000, 5'd7, 1'b1);
        repeat (8) stepCycle();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midmul_reset_control", 16'(bus.control_ex), 16'(NOP));
        checkOutput("midmul_reset_result", bus.result_ex, 16'h0);
        checkOutput("midmul_reset_flags", 16'(bus.flags_ex), 16'h0);
        checkOutput("midmul_reset_stall", 16'(bus.stall_ex), 16'h0);
        setIdle();
        stepCycle();
        reset = 1'b0;
        stepCycle();
        applyStimulus(4'b1000, 16'h1234, 16'h0010, 16'h0000, 5'd8, 1'b1);
        pushExpect(4'b1000, 16'h2340, 16'h0, 5'd8, 1'b1, 4'b0000);
        repeat (17) stepCycle();
        setIdle();
        repeat (3) stepCycle();

        checkOutput("scoreboard_drained", 16'(sb.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
Pipeline execute stage, directly upstream of the memory-access stage. It takes decoded operands from the decode stage and computes single-cycle ALU results, or load/store effective addresses. It runs a 16-step iterative shift-add multiply that stalls decode while busy. All outputs are registered and drive the memory-access stage's *_ex inputs directly.

Parameters:
WIDTH, 16, datapath width (result, operands, store data)
MUL_STEPS, 16, multiply iterations; must equal WIDTH
NOP_OP, 4'b1111, control code emitted for bubbles

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
valid_id  input  1  decode presents a valid instruction
control_id  input  4  opcode from decode
operand_a_id  input  16  first operand / base register
operand_b_id  input  16  second operand / offset / shift amount
reg_data_id  input  16  store data register value
dest_reg_index_id  input  5  destination register index
dest_reg_write_en_id  input  1  destination write enable
flush_ex  input  1  synchronous squash of the current instruction
stall_ex  output  1  decode must hold its outputs while high
control_ex  output  4  registered opcode to memory access
result_ex  output  16  registered ALU result / effective address
reg_data_ex  output  16  registered store data
dest_reg_index_ex  output  5  registered destination index
dest_reg_write_en_ex  output  1  registered write enable
flags_ex  output  4  {Z,N,C,V}, registered

Behaviour:
- Reset (async, high) forces:
  - control_ex=NOP_OP; result_ex, reg_data_ex, dest_reg_index_ex, flags_ex = 0; dest_reg_write_en_ex=0.
  - FSM=IDLE, multiply counter=0, stall_ex=0.
- Opcodes and results:
  - 0000 ADD: a+b. 0001 SUB: a-b. 0010 AND. 0011 OR. 0100 XOR. 0101 NOT a.
  - 0110 SHL: a<<b[3:0]. 0111 SHR, logical: a>>b[3:0].
  - 1000 MUL: low 16 bits of a*b, unsigned.
  - 1101 LOAD and 1110 STORE: result=a+b; the address is bits [7:0] downstream.
  - 1111 NOP. Any other code is executed as a bubble.
- Bubble: control_ex=NOP_OP, dest_reg_write_en_ex=0, result_ex=0, reg_data_ex=0, flags held.
- Single-cycle ops: inputs sampled at a rising edge; outputs valid after that edge (latency 1). All input fields pass through unchanged with the result.
- reg_data_ex carries reg_data_id for STORE and is 0 otherwise.
- Flags: updated only by ADD, SUB and MUL; held for all other ops.
  - Z = result==0; N = result[15].
  - C = carry-out for ADD, borrow for SUB, 0 for MUL.
  - V = signed overflow for ADD/SUB, 0 for MUL.
- FSM states: IDLE, BUSY.
  - IDLE + valid MUL + no flush: capture a and b, counter=0, accumulator=0, go BUSY, emit bubble.
  - BUSY: each edge, add the shifted multiplicand if the current multiplier bit is 1, then shift and increment the counter.
  - BUSY with counter==MUL_STEPS-1: on that edge write the final product with MUL's fields, update flags, go IDLE.
- stall_ex, combinational:
  - high when (IDLE & valid_id & control_id==1000 & !flush_ex), or when (BUSY & counter<MUL_STEPS-1);
  - low on the final BUSY cycle, so decode advances on the same edge the product is written.
- MUL latency: presented in cycle 0; result visible after the 17th edge. stall_ex is high for cycles 0-15 and low in cycle 16.
- Decode holds all *_id inputs stable while stall_ex=1. The stage does not re-sample operands in BUSY.
- flush_ex=1 at an edge:
  - the output register takes a bubble, and a BUSY multiply aborts to IDLE with the counter cleared;
  - flush takes priority over MUL start and completion;
  - stall_ex is forced low during flush.
- valid_id=0 in IDLE: bubble.
- Reset asserted mid-MUL aborts immediately (async). No partial product ever reaches result_ex.
- Arithmetic wraps modulo 2^16. A shift amount of 0 passes a through; only b[3:0] is used, so the maximum shift is 15.

Test Plan:
- Reset with all inputs nonzero -> control_ex=1111, dest_reg_write_en_ex=0, result_ex=0, flags_ex=0, stall_ex=0.
- ADD 0x7FFF+0x0001 -> result_ex=0x8000 after 1 edge, flags {Z,N,C,V}=0101; SUB 0x0000-0x0001 -> 0xFFFF, flags 0110.
- STORE a=0x0010, b=0x0005, reg_data=0xBEEF -> control_ex=1110, result_ex=0x0015, reg_data_ex=0xBEEF, flags unchanged.
- MUL 0x0123*0x0045 -> stall_ex high for 16 cycles, bubbles meanwhile; after the 17th edge result_ex=0x4E6F, dest fields match. A following ADD is accepted on that same edge.
- MUL 0x00FF*0x0101 with flush_ex pulsed in BUSY cycle 5 -> bubble out, stall_ex low next cycle, FSM IDLE; the next ADD 2+3 gives 0x0005.
- Reset asserted in BUSY cycle 8 -> outputs return to reset values immediately, no MUL result is ever emitted, and the next MUL completes normally.
